wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Three-way round-robin writeback arbiter (ALU, LSU, CSR) feeding a
//            single register-file write port, combined with a per-register
//            outstanding-write scoreboard. The scoreboard is used for
//            issue-side hazard detection.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            {alu,lsu,csr}_*       - writeback requesters: valid/ready
//                                    handshake plus rd_wen/rd_addr/data
//            issue_*               - IDU issue recording (issue_ready may
//                                    stall an issue)
//            rs1/rs2_addr, _busy   - source-operand busy lookup
//            rf_we/waddr/wdata     - registered register-file write port
//            wb_done               - one-cycle pulse per completed writeback
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic             lsu_valid,
  input  logic             csr_valid,
  output logic             alu_ready,
  output logic             lsu_ready,
  output logic             csr_ready,
  input  logic             alu_rd_wen,
  input  logic             lsu_rd_wen,
  input  logic             csr_rd_wen,
  input  logic [4:0]       alu_rd_addr,
  input  logic [4:0]       lsu_rd_addr,
  input  logic [4:0]       csr_rd_addr,
  input  logic [WIDTH-1:0] alu_data,
  input  logic [WIDTH-1:0] lsu_data,
  input  logic [WIDTH-1:0] csr_data,
  input  logic             issue_valid,
  input  logic             issue_rd_wen,
  input  logic [4:0]       issue_rd_addr,
  output logic             issue_ready,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             wb_done
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // r_ptr holds the index of the highest-priority requester
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt [0:31];

  logic [2:0]       w_valid;
  logic [2:0]       w_grant;
  logic             w_xfer;
  logic             w_sel_wen;
  logic [4:0]       w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_commit;
  logic             w_issue_tgt;
  logic             w_issue_full;
  logic             w_commit_same;
  logic             w_issue_rec;
  logic [31:0]      w_inc_vec;
  logic [31:0]      w_dec_vec;

  assign w_valid = {csr_valid, lsu_valid, alu_valid};

  // Round-robin grant. The grant depends only on valids and the pointer,
  // so no ready depends on any other ready. Reset forces every grant low.
  always_comb begin
    w_grant = 3'b000;
    if (!rst) begin
      case (r_ptr)
        2'd1: begin
          if      (w_valid[1]) w_grant = 3'b010;
          else if (w_valid[2]) w_grant = 3'b100;
          else if (w_valid[0]) w_grant = 3'b001;
        end
        2'd2: begin
          if      (w_valid[2]) w_grant = 3'b100;
          else if (w_valid[0]) w_grant = 3'b001;
          else if (w_valid[1]) w_grant = 3'b010;
        end
        default: begin
          if      (w_valid[0]) w_grant = 3'b001;
          else if (w_valid[1]) w_grant = 3'b010;
          else if (w_valid[2]) w_grant = 3'b100;
        end
      endcase
    end
  end

  assign alu_ready = w_grant[0];
  assign lsu_ready = w_grant[1];
  assign csr_ready = w_grant[2];
  assign w_xfer    = |w_grant;

  // Mux of the winning requester's writeback fields
  always_comb begin
    w_sel_wen  = alu_rd_wen;
    w_sel_addr = alu_rd_addr;
    w_sel_data = alu_data;
    if (w_grant[1]) begin
      w_sel_wen  = lsu_rd_wen;
      w_sel_addr = lsu_rd_addr;
      w_sel_data = lsu_data;
    end else if (w_grant[2]) begin
      w_sel_wen  = csr_rd_wen;
      w_sel_addr = csr_rd_addr;
      w_sel_data = csr_data;
    end
  end

  assign w_commit = w_xfer & w_sel_wen & (w_sel_addr != 5'd0);

  // An issue to a saturated counter is still accepted when a same-cycle
  // commit frees a slot in that very register.
  assign w_issue_tgt   = issue_rd_wen & (issue_rd_addr != 5'd0);
  assign w_issue_full  = (r_cnt[issue_rd_addr] == C_CNT_MAX);
  assign w_commit_same = w_commit & (w_sel_addr == issue_rd_addr);
  assign issue_ready   = ~rst & ~(w_issue_tgt & w_issue_full & ~w_commit_same);
  assign w_issue_rec   = issue_valid & issue_ready & w_issue_tgt;

  // One-hot increment/decrement requests; bit 0 never fires because both
  // sources already exclude x0.
  assign w_inc_vec = w_issue_rec ? (32'd1 << issue_rd_addr) : 32'd0;
  assign w_dec_vec = w_commit    ? (32'd1 << w_sel_addr)    : 32'd0;

  // No bypass: busy reflects the counter before this cycle's commit
  assign rs1_busy = (rs1_addr != 5'd0) & (r_cnt[rs1_addr] != '0);
  assign rs2_busy = (rs2_addr != 5'd0) & (r_cnt[rs2_addr] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= 2'd0;
      rf_we    <= 1'b0;
      wb_done  <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      rf_we   <= w_commit;
      wb_done <= w_xfer;
      if (w_xfer) begin
        rf_waddr <= w_sel_addr;
        rf_wdata <= w_sel_data;
      end

      if (w_grant[0])      r_ptr <= 2'd1;
      else if (w_grant[1]) r_ptr <= 2'd2;
      else if (w_grant[2]) r_ptr <= 2'd0;

      // Simultaneous inc and dec cancel; a decrement at zero is dropped
      for (int i = 0; i < 32; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
        end else if (w_dec_vec[i] && !w_inc_vec[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - C_CNT_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire
